param_dual_port_ram: RTL and testbench

PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

---
 rtl/dpram_pkg.sv | 18 +
 rtl/dpram_init_ctrl.sv | 70 +++++++
 rtl/param_dual_port_ram.sv | 128 ++++++++++++
 tb/tb_param_dual_port_ram.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared types and defaults for param_dual_port_ram and its init controller.
//   init_state_t   : INIT (post-reset clear sweep) / READY (normal operation)
//   DEFAULT_DATA_W : default word width
//   DEFAULT_DEPTH  : default number of words (power of two)
// -----------------------------------------------------------------------------
package dpram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 32;

endpackage : dpram_pkg

// File: rtl/dpram_init_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_init_ctrl
// Post-reset clear sweep. After rst the controller walks every address once,
// asking the RAM to write zero there, then parks in READY.
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high; restarts the sweep at address 0
//   busy       : high while the sweep runs (exactly DEPTH cycles after rst)
//   clear_addr : address being cleared this cycle
//   clear_we   : write-zero strobe for clear_addr
// -----------------------------------------------------------------------------
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              clear_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned (no inferred latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        clear_we   = 1'b0;
        clear_addr = cnt_q;
        case (state_q)
            INIT: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                // The last address is written on the cycle we leave INIT; the
                // counter parks there instead of wrapping.
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule : dpram_init_ctrl

// File: rtl/param_dual_port_ram.sv
// -----------------------------------------------------------------------------
// param_dual_port_ram
// True dual-port RAM with registered reads, per-port output enable, a
// same-address write collision flag and a post-reset zeroing sweep.
//   clk, rst                    : clock, synchronous active-high reset
//   cs_x, wr_x                  : chip select, 1 = write / 0 = read
//   out_en_x                    : output enable (d_out_x forced to 0 when low)
//   add_x, d_in_x               : word address, write data
//   d_out_x, valid_x            : registered read data, one-cycle fresh flag
//   busy                        : clear sweep in progress, ports ignored
//   collision                   : pulse after both ports wrote one address
// Optional build macro DPRAM_WRITE_THROUGH_EN: an accepted write also loads
// d_in_x into port x's output register and pulses valid_x.
// -----------------------------------------------------------------------------
module param_dual_port_ram
    import dpram_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_a,
    input  logic              cs_b,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic              out_en_a,
    input  logic              out_en_b,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] d_in_a,
    input  logic [DATA_W-1:0] d_in_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy,
    output logic              collision
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;

    dpram_init_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .clear_addr (clear_addr),
        .clear_we   (clear_we)
    );

    // Port accesses are only honoured once the sweep is done and outside reset.
    logic acc_a, acc_b, rd_a, rd_b, wr_acc_a, wr_acc_b, coll, we_b;

    always_comb begin
        acc_a    = cs_a && !busy && !rst;
        acc_b    = cs_b && !busy && !rst;
        rd_a     = acc_a && !wr_a;
        rd_b     = acc_b && !wr_b;
        wr_acc_a = acc_a && wr_a;
        wr_acc_b = acc_b && wr_b;
        // Same-address dual write: port A wins, port B's store is dropped.
        coll     = wr_acc_a && wr_acc_b && (add_a == add_b);
        we_b     = wr_acc_b && !coll;
    end

    // NOTE: the storage array has no reset; it is cleared by the sweep
    // instead, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end
        if (wr_acc_a) begin
            mem[add_a] <= d_in_a;
        end
        if (we_b) begin
            mem[add_b] <= d_in_b;
        end
    end

    // Reads sample the array before this edge's writes land, so a read of an
    // address written by the other port in the same cycle returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a   <= '0;
            rdata_b   <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            collision <= coll;
            if (rd_a) begin
                rdata_a <= mem[add_a];
                valid_a <= 1'b1;
            end
`ifdef DPRAM_WRITE_THROUGH_EN
            else if (wr_acc_a) begin
                rdata_a <= d_in_a;
                valid_a <= 1'b1;
            end
`endif
            if (rd_b) begin
                rdata_b <= mem[add_b];
                valid_b <= 1'b1;
            end
`ifdef DPRAM_WRITE_THROUGH_EN
            // Port B still sees its own data even when the store was dropped.
            else if (wr_acc_b) begin
                rdata_b <= d_in_b;
                valid_b <= 1'b1;
            end
`endif
        end
    end

    // Output enable only gates the pins; register and valid are untouched.
    assign d_out_a = out_en_a ? rdata_a : '0;
    assign d_out_b = out_en_b ? rdata_b : '0;

endmodule : param_dual_port_ram

// File: tb/tb_param_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_param_dual_port_ram
// Directed bench for param_dual_port_ram (DATA_W=8, DEPTH=32). Each clock the
// bench's own behavioural model predicts every output, pushes the prediction
// to a queue, and pops/compares it one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_param_dual_port_ram;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_a, cs_b, wr_a, wr_b, out_en_a, out_en_b;
    logic [ADDR_W-1:0] add_a, add_b;
    logic [DATA_W-1:0] d_in_a, d_in_b;
    logic [DATA_W-1:0] d_out_a, d_out_b;
    logic              valid_a, valid_b, busy, collision;

    param_dual_port_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_a      (cs_a),
        .cs_b      (cs_b),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .out_en_a  (out_en_a),
        .out_en_b  (out_en_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .d_in_a    (d_in_a),
        .d_in_b    (d_in_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .busy      (busy),
        .collision (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              busy;
        logic              va;
        logic              vb;
        logic              col;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_reg_a = '0;
    logic [DATA_W-1:0] m_reg_b = '0;
    int                m_busy_cnt = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ca, input logic wa, input logic [ADDR_W-1:0] aa,
                         input logic [DATA_W-1:0] da,
                         input logic cb, input logic wb, input logic [ADDR_W-1:0] ab,
                         input logic [DATA_W-1:0] db);
        cs_a = ca; wr_a = wa; add_a = aa; d_in_a = da;
        cs_b = cb; wr_b = wb; add_b = ab; d_in_b = db;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic tick();
        exp_t              e, got;
        logic [DATA_W-1:0] rda, rdb;
        logic              wa_ok, wb_ok, coll;
        e.va  = 1'b0;
        e.vb  = 1'b0;
        e.col = 1'b0;
        if (rst) begin
            m_reg_a    = '0;
            m_reg_b    = '0;
            m_busy_cnt = DEPTH;
        end else if (m_busy_cnt != 0) begin
            m_mem[DEPTH - m_busy_cnt] = '0;
            m_busy_cnt--;
        end else begin
            rda   = m_mem[add_a];
            rdb   = m_mem[add_b];
            wa_ok = cs_a && wr_a;
            wb_ok = cs_b && wr_b;
            coll  = wa_ok && wb_ok && (add_a == add_b);
            if (cs_a && !wr_a) begin m_reg_a = rda; e.va = 1'b1; end
            if (cs_b && !wr_b) begin m_reg_b = rdb; e.vb = 1'b1; end
`ifdef DPRAM_WRITE_THROUGH_EN
            if (wa_ok) begin m_reg_a = d_in_a; e.va = 1'b1; end
            if (wb_ok) begin m_reg_b = d_in_b; e.vb = 1'b1; end
`endif
            if (wb_ok && !coll) m_mem[add_b] = d_in_b;
            if (wa_ok) m_mem[add_a] = d_in_a;
            e.col = coll;
        end
        e.busy = (m_busy_cnt != 0);
        e.da   = out_en_a ? m_reg_a : '0;
        e.db   = out_en_b ? m_reg_b : '0;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("busy",      busy,      got.busy);
        check("valid_a",   valid_a,   got.va);
        check("valid_b",   valid_b,   got.vb);
        check("collision", collision, got.col);
        check("d_out_a",   d_out_a,   got.da);
        check("d_out_b",   d_out_b,   got.db);
    endtask

    // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        rst = 1'b1; out_en_a = 1'b1; out_en_b = 1'b1;
        idle();

        // Reset state and first sweep
        tick();
        tick();
        check("rst_busy", busy, 1'b1);
        check("rst_dout_a", d_out_a, 8'h00);
        rst = 1'b0;
        count_busy("sweep_len");

        // Every address reads zero on both ports
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 1'b0, ADDR_W'(DEPTH - 1 - i), '0);
            tick();
            check("zero_a", d_out_a, 8'h00);
            check("zero_b", d_out_b, 8'h00);
        end

        // A writes 0xA5 @3, B reads 3 next cycle
        drive(1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0);
        tick();
        check("rd3_b", d_out_b, 8'hA5);
        check("rd3_vb", valid_b, 1'b1);

        // Dual write to 7: A wins, collision pulses once
        drive(1'b1, 1'b1, 5'd7, 8'h11, 1'b1, 1'b1, 5'd7, 8'h22);
        tick();
        check("coll_pulse", collision, 1'b1);
        drive(1'b1, 1'b0, 5'd7, '0, 1'b0, 1'b0, '0, '0);
        tick();
        check("coll_drop", collision, 1'b0);
        check("rd7_a", d_out_a, 8'h11);

        // Read-during-write on 9 returns old data, re-read returns new
        drive(1'b1, 1'b1, 5'd9, 8'h5A, 1'b1, 1'b0, 5'd9, '0);
        tick();
        check("rdw_old", d_out_b, 8'h00);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd9, '0);
        tick();
        check("rdw_new", d_out_b, 8'h5A);

        // Output enable gates pins only
        out_en_a = 1'b0;
        drive(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0);
        tick();
        check("oe_gated", d_out_a, 8'h00);
        check("oe_valid", valid_a, 1'b1);
        out_en_a = 1'b1;
        idle();
        tick();
        check("oe_latched", d_out_a, 8'hA5);
        check("oe_novalid", valid_a, 1'b0);

        // Mixed traffic on a narrow address range to provoke collisions
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                  1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
            out_en_a = 1'($urandom);
            out_en_b = 1'($urandom);
            tick();
        end
        out_en_a = 1'b1;
        out_en_b = 1'b1;

        // Reset mid-sweep restarts the full sweep
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 8'hEE, 1'b0, 1'b0, '0, '0);
        tick();
        idle();
        rst = 1'b0;
        count_busy("resweep_len");

        // Write then read after the restarted sweep
        drive(1'b1, 1'b1, 5'd5, 8'h3C, 1'b0, 1'b0, '0, '0);
        tick();
`ifdef DPRAM_WRITE_THROUGH_EN
        check("wt_data", d_out_a, 8'h3C);
        check("wt_valid", valid_a, 1'b1);
`else
        check("nowt_hold", d_out_a, 8'h00);
        check("nowt_valid", valid_a, 1'b0);
`endif
        drive(1'b1, 1'b0, 5'd5, '0, 1'b1, 1'b0, 5'd6, '0);
        tick();
        check("rd5_a", d_out_a, 8'h3C);
        check("rd6_b", d_out_b, 8'h00);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_param_dual_port_ram
